// File: rtl/hc_responder.sv
// HardCloud CCI-P response side: read-data FIFO, outstanding-request tracking, read credit and drain detect.
// Optional HC_RESPONDER_STATS_EN adds stat_rd_lines / stat_wr_lines / stat_stall_cycles outputs.

package ccip_if_pkg;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h8
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

endpackage

module hc_responder
  import ccip_if_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 64,
  parameter int NUM_BUF        = 4,
  parameter int ID_W           = $clog2(NUM_BUF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  t_if_ccip_Rx       ccip_rx,
  input  logic              rd_issued,
  input  logic              wr_issued,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [511:0]      rsp_data,
  input  logic              rsp_ready,
  output logic              rd_credit_ok,
  output logic [15:0]       rd_outstanding,
  output logic [15:0]       wr_outstanding,
  output logic              drained,
  output logic              overflow_err,
  output logic              underflow_err
`ifdef HC_RESPONDER_STATS_EN
  ,
  output logic [31:0]       stat_rd_lines,
  output logic [31:0]       stat_wr_lines,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int AW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_RSP_IDLE,
    S_RSP_RUN,
    S_RSP_DRAIN,
    S_RSP_DONE
  } rsp_state_e;

  rsp_state_e state;

  logic            rd_rsp_acc;
  logic            wr_rsp_acc;
  logic            rx_rd_valid_q;
  logic [ID_W-1:0] rx_rd_id_q;
  logic [511:0]    rx_rd_data_q;
  logic            rd_issued_q;

  logic [ID_W-1:0] mem_id   [RSP_FIFO_DEPTH];
  logic [511:0]    mem_data [RSP_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            push;
  logic            pop;

  logic [16:0]     credit_sum;
  logic            drain_cond;
  logic            start_run;
  logic            unused_rx;

  assign rd_rsp_acc = ccip_rx.c0.rspValid && (ccip_rx.c0.hdr.resp_type == eRSP_RDLINE);
  assign wr_rsp_acc = ccip_rx.c1.rspValid;
  assign unused_rx  = &{1'b0, ccip_rx};

  // Saturating up/down count; simultaneous issue and response cancel out.
  function automatic logic [15:0] cnt_next(input logic [15:0] cnt, input logic inc,
                                           input logic dec);
    cnt_next = cnt;
    if (inc && !dec && cnt != 16'hFFFF) cnt_next = cnt + 16'd1;
    else if (dec && !inc && cnt != 16'd0) cnt_next = cnt - 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_rd_valid_q <= 1'b0;
      rx_rd_id_q    <= '0;
      rx_rd_data_q  <= '0;
      rd_issued_q   <= 1'b0;
    end else begin
      rx_rd_valid_q <= rd_rsp_acc;
      rd_issued_q   <= rd_issued;
      if (rd_rsp_acc) begin
        rx_rd_id_q   <= ccip_rx.c0.hdr.mdata[ID_W-1:0];
        rx_rd_data_q <= ccip_rx.c0.data;
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign fifo_full = (fifo_count == CW'(RSP_FIFO_DEPTH));
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rx_rd_valid_q && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= rx_rd_id_q;
      mem_data[wr_ptr] <= rx_rd_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (rx_rd_valid_q && fifo_full && !pop) overflow_err <= 1'b1;
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      underflow_err  <= 1'b0;
    end else begin
      rd_outstanding <= cnt_next(rd_outstanding, rd_issued, rd_rsp_acc);
      wr_outstanding <= cnt_next(wr_outstanding, wr_issued, wr_rsp_acc);
      if ((rd_rsp_acc && !rd_issued && rd_outstanding == 16'd0) ||
          (wr_rsp_acc && !wr_issued && wr_outstanding == 16'd0))
        underflow_err <= 1'b1;
    end
  end

  // The input register counts as FIFO occupancy so the credit never opens
  // during the cycle a returned line sits between the counter and the FIFO.
  assign credit_sum = {1'b0, rd_outstanding} + 17'(fifo_count) + 17'(rx_rd_valid_q)
                    + 17'(rd_issued_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_credit_ok <= 1'b1;
    else       rd_credit_ok <= (credit_sum < 17'(RSP_FIFO_DEPTH));
  end

  assign drain_cond = (rd_outstanding == 16'd0) && (wr_outstanding == 16'd0) &&
                      (fifo_count == '0) && !rx_rd_valid_q;
  assign start_run  = (state == S_RSP_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RSP_IDLE;
      drained <= 1'b0;
    end else begin
      case (state)
        S_RSP_IDLE: begin
          drained <= 1'b0;
          if (start) state <= S_RSP_RUN;
        end
        S_RSP_RUN: begin
          drained <= 1'b0;
          if (finish) state <= S_RSP_DRAIN;
        end
        S_RSP_DRAIN: begin
          if (drain_cond) begin
            state   <= S_RSP_DONE;
            drained <= 1'b1;
          end
        end
        S_RSP_DONE: begin
          drained <= 1'b1;
          if (!start) begin
            state   <= S_RSP_IDLE;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= S_RSP_IDLE;
          drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef HC_RESPONDER_STATS_EN
  // Statistics restart with every new run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_lines     <= '0;
      stat_wr_lines     <= '0;
      stat_stall_cycles <= '0;
    end else if (start_run) begin
      stat_rd_lines     <= '0;
      stat_wr_lines     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (rd_rsp_acc)              stat_rd_lines     <= stat_rd_lines + 32'd1;
      if (wr_rsp_acc)              stat_wr_lines     <= stat_wr_lines + 32'd1;
      if (rsp_valid && !rsp_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`else
  logic unused_start_run;
  assign unused_start_run = start_run;
`endif

endmodule
